// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared constants and state encoding for the Keccak-512 absorb controller
package keccak_pkg;

    localparam int RATE_BITS = 576;
    localparam int LANES     = 9;
    localparam int LANE_W    = 64;
    localparam int DIGEST_W  = 512;
    localparam int STATE_W   = 1600;
    localparam int CNT_W     = $clog2(LANES);

    localparam logic [7:0] PAD_FIRST = 8'h01;
    localparam logic [7:0] PAD_LAST  = 8'h80;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/keccak_pad_lane.sv
// rtl/keccak_pad_lane.sv - builds the final lane: in_bytes data bytes, then 0x01, then zeros
module keccak_pad_lane
    import keccak_pkg::*;
(
    input  logic [LANE_W-1:0] in_data_i,
    input  logic [2:0]        in_bytes_i,
    output logic [LANE_W-1:0] lane_o
);

    always_comb begin
        lane_o = '0;
        for (int b = 0; b < LANE_W / 8; b++) begin
            if (b < int'(in_bytes_i)) begin
                lane_o[8*b +: 8] = in_data_i[8*b +: 8];
            end else if (b == int'(in_bytes_i)) begin
                lane_o[8*b +: 8] = PAD_FIRST;
            end
        end
    end

endmodule

// File: rtl/keccak_absorb_ctrl.sv
// rtl/keccak_absorb_ctrl.sv - packs message words into padded rate blocks, sequences the
// permutation core one block at a time and holds the digest for the consumer
module keccak_absorb_ctrl #(
    parameter int LANES  = keccak_pkg::LANES,
    parameter int LANE_W = keccak_pkg::LANE_W,
    parameter int OUT_W  = keccak_pkg::DIGEST_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANE_W-1:0]         in_data,
    input  logic                      in_valid,
    input  logic                      in_last,
    input  logic [2:0]                in_bytes,
    output logic                      in_ready,
    output logic [LANES*LANE_W-1:0]   perm_block,
    output logic                      perm_first,
    output logic                      perm_start,
    input  logic                      perm_done,
    input  logic [1599:0]             perm_state,
    output logic [OUT_W-1:0]          digest,
    output logic                      digest_valid,
    input  logic                      digest_ready
);

    import keccak_pkg::*;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          lane_cnt_q, lane_cnt_d;
    logic                      first_flag_q, first_flag_d;
    logic                      last_blk_q, last_blk_d;
    logic [LANES*LANE_W-1:0]   block_q, block_d;
    logic                      perm_first_q, perm_first_d;
    logic [OUT_W-1:0]          digest_q, digest_d;
    logic                      digest_valid_q, digest_valid_d;
    logic [LANE_W-1:0]         pad_lane;
    logic                      unused_state_hi;

    assign unused_state_hi = ^perm_state[1599:OUT_W];

    keccak_pad_lane u_pad_lane (
        .in_data_i  (in_data),
        .in_bytes_i (in_bytes),
        .lane_o     (pad_lane)
    );

    always_comb begin
        state_d        = state_q;
        lane_cnt_d     = lane_cnt_q;
        first_flag_d   = first_flag_q;
        last_blk_d     = last_blk_q;
        block_d        = block_q;
        perm_first_d   = perm_first_q;
        digest_d       = digest_q;
        digest_valid_d = digest_valid_q;

        unique case (state_q)
            ST_FILL: begin
                if (in_valid) begin
                    if (in_last) begin
                        // Padding always fits: the current lane takes 0x01, later lanes clear,
                        // and the top byte of the block gets 0x80 (merging to 0x81 if shared).
                        for (int i = 0; i < LANES; i++) begin
                            if (i == int'(lane_cnt_q)) begin
                                block_d[i*LANE_W +: LANE_W] = pad_lane;
                            end else if (i > int'(lane_cnt_q)) begin
                                block_d[i*LANE_W +: LANE_W] = '0;
                            end
                        end
                        block_d[LANES*LANE_W-1 -: 8] = block_d[LANES*LANE_W-1 -: 8] | PAD_LAST;
                        last_blk_d   = 1'b1;
                        lane_cnt_d   = '0;
                        perm_first_d = first_flag_q;
                        state_d      = ST_ISSUE;
                    end else begin
                        for (int i = 0; i < LANES; i++) begin
                            if (i == int'(lane_cnt_q)) begin
                                block_d[i*LANE_W +: LANE_W] = in_data;
                            end
                        end
                        if (lane_cnt_q == CNT_W'(LANES - 1)) begin
                            last_blk_d   = 1'b0;
                            lane_cnt_d   = '0;
                            perm_first_d = first_flag_q;
                            state_d      = ST_ISSUE;
                        end else begin
                            lane_cnt_d = lane_cnt_q + 1'b1;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                first_flag_d = 1'b0;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                if (perm_done) begin
                    if (last_blk_q) begin
                        digest_d       = perm_state[OUT_W-1:0];
                        digest_valid_d = 1'b1;
                        state_d        = ST_DONE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_DONE: begin
                if (digest_ready) begin
                    digest_valid_d = 1'b0;
                    first_flag_d   = 1'b1;
                    state_d        = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_FILL;
            lane_cnt_q     <= '0;
            first_flag_q   <= 1'b1;
            last_blk_q     <= 1'b0;
            block_q        <= '0;
            perm_first_q   <= 1'b0;
            digest_q       <= '0;
            digest_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            lane_cnt_q     <= lane_cnt_d;
            first_flag_q   <= first_flag_d;
            last_blk_q     <= last_blk_d;
            block_q        <= block_d;
            perm_first_q   <= perm_first_d;
            digest_q       <= digest_d;
            digest_valid_q <= digest_valid_d;
        end
    end

    assign in_ready     = (state_q == ST_FILL);
    assign perm_start   = (state_q == ST_ISSUE);
    assign perm_block   = block_q;
    assign perm_first   = perm_first_q;
    assign digest       = digest_q;
    assign digest_valid = digest_valid_q;

endmodule

// File: tb/tb_keccak_absorb_ctrl.sv
// tb/tb_keccak_absorb_ctrl.sv - directed self-checking bench for keccak_absorb_ctrl
module tb_keccak_absorb_ctrl;

    logic           clk = 1'b0;
    logic           rst;
    logic [63:0]    in_data;
    logic           in_valid;
    logic           in_last;
    logic [2:0]     in_bytes;
    logic           in_ready;
    logic [575:0]   perm_block;
    logic           perm_first;
    logic           perm_start;
    logic           perm_done;
    logic [1599:0]  perm_state;
    logic [511:0]   digest;
    logic           digest_valid;
    logic           digest_ready;

    int n_checks = 0;
    int n_errors = 0;

    logic [1599:0]  s1, s2, s3;
    logic [575:0]   exp_blk;
    logic [575:0]   held_blk;
    logic [511:0]   held_dig;

    always #5 clk = ~clk;

    keccak_absorb_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_bytes     (in_bytes),
        .in_ready     (in_ready),
        .perm_block   (perm_block),
        .perm_first   (perm_first),
        .perm_start   (perm_start),
        .perm_done    (perm_done),
        .perm_state   (perm_state),
        .digest       (digest),
        .digest_valid (digest_valid),
        .digest_ready (digest_ready)
    );

    task automatic check_eq(input string tag, input logic [575:0] got, input logic [575:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] word(input int i);
        return 64'h0123_4567_89AB_CDEF ^ (64'h1111_1111_1111_1111 * 64'(i));
    endfunction

    task automatic send_word(input logic [63:0] d, input logic last, input logic [2:0] nb);
        int n;
        n = 0;
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check_eq("send_timeout", 576'(in_ready), 576'(1));
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bytes = 3'd0;
    endtask

    task automatic finish_perm(input logic [1599:0] st);
        tick();
        perm_done  = 1'b1;
        perm_state = st;
        tick();
        perm_done  = 1'b0;
    endtask

    task automatic ack_digest();
        digest_ready = 1'b1;
        tick();
        digest_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; in_bytes = '0;
        perm_done = 1'b0; perm_state = '0; digest_ready = 1'b0;
        for (int i = 0; i < 25; i++) begin
            s1[64*i +: 64] = {32'h5EED_0000 + 32'(i), 32'hC0DE_0000 + 32'(i)};
            s2[64*i +: 64] = {32'hA5A5_1000 + 32'(i), 32'h3C3C_2000 + 32'(i)};
            s3[64*i +: 64] = {32'h0F0F_3000 + 32'(i), 32'h7777_4000 + 32'(i)};
        end
        tick(); tick();
        rst = 1'b1;

        check_eq("rst_in_ready", 576'(in_ready), 576'(1));
        check_eq("rst_perm_start", 576'(perm_start), 576'(0));
        check_eq("rst_perm_first", 576'(perm_first), 576'(0));
        check_eq("rst_perm_block", perm_block, 576'(0));
        check_eq("rst_digest", 576'(digest), 576'(0));
        check_eq("rst_digest_valid", 576'(digest_valid), 576'(0));

        // Empty message
        send_word(64'hDEAD_BEEF_0BAD_F00D, 1'b1, 3'd0);
        exp_blk = '0;
        exp_blk[7:0] = 8'h01;
        exp_blk[575:568] = 8'h80;
        check_eq("empty_start", 576'(perm_start), 576'(1));
        check_eq("empty_first", 576'(perm_first), 576'(1));
        check_eq("empty_in_ready", 576'(in_ready), 576'(0));
        check_eq("empty_block", perm_block, exp_blk);
        tick();
        check_eq("start_one_cycle", 576'(perm_start), 576'(0));
        in_valid = 1'b1; in_data = 64'hFFFF_FFFF_FFFF_FFFF; in_last = 1'b0;
        tick();
        check_eq("wait_no_ready", 576'(in_ready), 576'(0));
        check_eq("wait_block_stable", perm_block, exp_blk);
        perm_done = 1'b1; perm_state = s1;
        tick();
        perm_done = 1'b0; in_valid = 1'b0;
        check_eq("empty_dvalid", 576'(digest_valid), 576'(1));
        check_eq("empty_digest", 576'(digest), 576'(s1[511:0]));
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("bp_dvalid", 576'(digest_valid), 576'(1));
            check_eq("bp_digest", 576'(digest), 576'(s1[511:0]));
            check_eq("bp_in_ready", 576'(in_ready), 576'(0));
        end
        ack_digest();
        check_eq("ack_dvalid", 576'(digest_valid), 576'(0));
        check_eq("ack_in_ready", 576'(in_ready), 576'(1));
        check_eq("ack_digest_held", 576'(digest), 576'(s1[511:0]));

        // 71-byte message: 0x01 and 0x80 share byte 71
        for (int i = 0; i < 8; i++) send_word(word(i), 1'b0, 3'd0);
        send_word(64'hAABB_CCDD_EEFF_1122, 1'b1, 3'd7);
        for (int i = 0; i < 8; i++) exp_blk[64*i +: 64] = word(i);
        exp_blk[575:512] = 64'h81BB_CCDD_EEFF_1122;
        check_eq("b71_start", 576'(perm_start), 576'(1));
        check_eq("b71_first", 576'(perm_first), 576'(1));
        check_eq("b71_block", perm_block, exp_blk);
        finish_perm(s2);
        check_eq("b71_digest", 576'(digest), 576'(s2[511:0]));
        ack_digest();

        // 72-byte message: full block, then pad-only block
        for (int i = 0; i < 9; i++) send_word(word(i + 10), 1'b0, 3'd0);
        for (int i = 0; i < 9; i++) exp_blk[64*i +: 64] = word(i + 10);
        check_eq("b72_lat_start", 576'(perm_start), 576'(1));
        check_eq("b72_first1", 576'(perm_first), 576'(1));
        check_eq("b72_block1", perm_block, exp_blk);
        tick();
        check_eq("b72_first_stable", 576'(perm_first), 576'(1));
        perm_done = 1'b1; perm_state = s3;
        tick();
        perm_done = 1'b0;
        check_eq("b72_ready_after_done", 576'(in_ready), 576'(1));
        check_eq("b72_no_dvalid", 576'(digest_valid), 576'(0));
        perm_done = 1'b1;
        tick();
        perm_done = 1'b0;
        check_eq("fill_done_ignored_rdy", 576'(in_ready), 576'(1));
        check_eq("fill_done_ignored_dv", 576'(digest_valid), 576'(0));
        send_word(64'h1234_5678_9ABC_DEF0, 1'b1, 3'd0);
        exp_blk = '0;
        exp_blk[7:0] = 8'h01;
        exp_blk[575:568] = 8'h80;
        check_eq("b72_first2", 576'(perm_first), 576'(0));
        check_eq("b72_block2", perm_block, exp_blk);
        finish_perm(s3);
        check_eq("b72_digest", 576'(digest), 576'(s3[511:0]));
        ack_digest();

        // Partial last lane, then reset while waiting on the core
        send_word(word(20), 1'b0, 3'd0);
        send_word(64'h1122_3344_5566_7788, 1'b1, 3'd3);
        exp_blk = '0;
        exp_blk[63:0] = word(20);
        exp_blk[127:64] = 64'h0000_0000_0166_7788;
        exp_blk[575:568] = 8'h80;
        check_eq("part_first", 576'(perm_first), 576'(1));
        check_eq("part_block", perm_block, exp_blk);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_eq("rst_wait_dvalid", 576'(digest_valid), 576'(0));
        check_eq("rst_wait_in_ready", 576'(in_ready), 576'(1));
        perm_done = 1'b1; perm_state = s1;
        tick();
        perm_done = 1'b0;
        check_eq("stray_done_dvalid", 576'(digest_valid), 576'(0));
        check_eq("stray_done_ready", 576'(in_ready), 576'(1));
        send_word(64'h0, 1'b1, 3'd0);
        check_eq("first_after_reset", 576'(perm_first), 576'(1));
        finish_perm(s2);
        check_eq("post_rst_digest", 576'(digest), 576'(s2[511:0]));
        ack_digest();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keccak_absorb_ctrl.md
Name: keccak_absorb_ctrl

Overview:
- Sequences multi-block Keccak-512 hashing: accepts the message as 64-bit words over a valid/ready stream and packs them into 576-bit rate blocks (9 lanes).
- Applies pad10*1 (byte 0x01 … 0x80) to the final block.
- Drives the shared permutation core with a start/done handshake, one block at a time, and flags the first block of each message so the core clears its state.
- Captures the 512-bit digest and holds it until the consumer accepts it.

Parameters:
- LANES, 9, lanes per rate block (576/64)
- LANE_W, 64, bits per input word / lane
- OUT_W, 512, digest width taken from the low bits of the permuted state

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-low
- in_data  in  64  message word; byte b is at bits [8b+7:8b] (little-endian)
- in_valid  in  1  word present
- in_last  in  1  final word of the message
- in_bytes  in  3  valid bytes in the last word, 0..7; only used when in_last=1
- in_ready  out  1  controller accepts a word this cycle
- perm_block  out  576  rate block; lane i at [64i+63:64i]
- perm_first  out  1  block is the first of its message (core zeroes state before absorbing)
- perm_start  out  1  single-cycle request to permute perm_block
- perm_done  in  1  core finished; perm_state valid this cycle
- perm_state  in  1600  permuted state from the core
- digest  out  512  hash result
- digest_valid  out  1  digest held
- digest_ready  in  1  consumer takes the digest

Behaviour:
- States: FILL, ISSUE, WAIT, DONE. Reset (rst=0 at a clk edge) puts the block in FILL, regardless of current state.
- Reset values:
  - lane_cnt=0, first_flag=1, last_blk=0
  - perm_block=0, perm_first=0, perm_start=0
  - digest=0, digest_valid=0
  - in_ready=1 after reset (comes from FILL)
- Word acceptance: a word is accepted when in_valid && in_ready. in_ready=1 only in FILL.
- FILL, non-last word: word is written to lane lane_cnt, then lane_cnt increments.
  - If lane_cnt was 8: go to ISSUE with last_blk=0, lane_cnt=0.
- FILL, last word: lane lane_cnt gets in_bytes data bytes, then byte 0x01 at byte position in_bytes, then zero in the rest of that lane.
  - All lanes above lane_cnt are zeroed.
  - Bit 575 (byte 71) is ORed with 0x80. If the 0x01 byte lands at byte 71 (lane 8, in_bytes=7), byte 71 = 0x81.
  - Padding therefore always fits in the current block; an extra pad-only block is never needed.
  - Go to ISSUE with last_blk=1, lane_cnt=0.
  - With in_last=1 and in_bytes=0, in_data is ignored.
- ISSUE: perm_start=1 for exactly one cycle, perm_first=first_flag. Then first_flag=0 and go to WAIT.
- perm_block and perm_first stay stable from ISSUE until the cycle perm_done is sampled in WAIT.
- WAIT: on perm_done:
  - if last_blk=1: digest<=perm_state[511:0], digest_valid<=1, go to DONE.
  - otherwise go to FILL.
- perm_done outside WAIT is ignored.
- DONE: digest_valid holds until digest_ready=1. On that cycle digest_valid<=0, first_flag<=1, go to FILL. digest keeps its value until the next capture.
- Latency:
  - accept of the 9th or last word → perm_start on the next cycle.
  - perm_done → digest_valid on the next cycle.
  - perm_done (non-last block) → in_ready on the next cycle.
- perm_block is a registered output. Lanes not yet written in the current block are don't-care until padding zeroes them; lanes of the previous block may persist.
- Reset during WAIT abandons the block. A later perm_done is ignored and the next message starts with perm_first=1.

Decomposition:
- Shared package keccak_pkg: RATE_BITS=576, LANES=9, LANE_W=64, DIGEST_W=512, PAD_FIRST=8'h01, PAD_LAST=8'h80, state encoding.
- One natural sub-module: keccak_pad_lane. Combinational; takes in_data and in_bytes and returns the padded 64-bit lane.

Test Plan:
- Empty message: in_last=1, in_bytes=0 at lane 0 → one perm_start, perm_first=1, perm_block[7:0]=0x01, perm_block[575:568]=0x80, all other bits 0.
- 71-byte message: 8 full words then in_last, in_bytes=7 → single block, perm_block[575:568]=0x81, lanes 0-7 equal the input words.
- 72-byte message: 9 full words → block 1 issued with perm_first=1. After perm_done, the last word with in_bytes=0 → block 2 with perm_first=0, bytes 0x01…0x80, digest = perm_state[511:0] of the 2nd perm_done.
- Backpressure: digest_ready=0 for 5 cycles in DONE → digest_valid and digest stable, in_ready=0. Raise digest_ready → the next message's first block has perm_first=1.
- Handshake robustness: perm_done pulsed during FILL → ignored. in_valid held in WAIT → no word accepted.
- Reset mid-operation: rst=0 during WAIT for 1 cycle → digest_valid=0, in_ready=1, a stray perm_done is ignored, the next block has perm_first=1.
